// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the NOP instruction word and the default fetch timeout.
// The optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        REISSUE = 2'd2
    } fetch_state_e;

    // A NOP is the all-zero word at any bus width.
    localparam int unsigned NOP = 0;

    localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register. A jump load takes priority over an increment,
// and the increment wraps naturally at 2^PC_WIDTH.
module fetch_pc #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pc_inc_i,
    input  logic                jump_i,
    input  logic [PC_WIDTH-1:0] jump_addr_i,
    output logic [PC_WIDTH-1:0] pc_o
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    // Next PC: jump target beats increment, otherwise hold.
    always_comb begin
        pc_d = pc_q;
        if (jump_i) begin
            pc_d = jump_addr_i;
        end else if (pc_inc_i) begin
            pc_d = pc_q + PC_WIDTH'(1);
        end
    end

    // PC register, cleared to address 0 on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues instruction-memory reads at the current PC,
// latches the returned word into the instruction register and squashes
// fetches made stale by a jump, reissuing them at the new PC.
// Define FETCH_TIMEOUT_EN to abort a fetch after TIMEOUT unanswered WAIT cycles.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int BUS_WIDTH = 16,
    parameter int PC_WIDTH  = 8,
    parameter int TIMEOUT   = int'(DEFAULT_TIMEOUT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 imem_read,
    input  logic                 pc_inc,
    input  logic                 jump,
    input  logic [PC_WIDTH-1:0]  jump_addr,
    input  logic                 imem_ack,
    input  logic [BUS_WIDTH-1:0] imem_rdata,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [BUS_WIDTH-1:0] ir,
    output logic [PC_WIDTH-1:0]  ir_pc,
    output logic                 ir_valid,
    output logic                 busy,
    output logic                 fetch_err
);

    fetch_state_e         state_q;
    logic [PC_WIDTH-1:0]  addr_q;
    logic                 req_q;
    logic                 stale_q;
    logic [BUS_WIDTH-1:0] ir_q;
    logic [PC_WIDTH-1:0]  ir_pc_q;
    logic                 ir_valid_q;
    logic                 squash;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    fetch_pc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_fetch_pc (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_inc_i    (pc_inc),
        .jump_i      (jump),
        .jump_addr_i (jump_addr),
        .pc_o        (pc)
    );

    // A jump arriving in the same cycle as the response still makes it stale.
    assign squash = stale_q | jump;

    // Fetch FSM with registered request, address latch, stale flag and IR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            req_q      <= 1'b0;
            stale_q    <= 1'b0;
            ir_q       <= BUS_WIDTH'(NOP);
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
`ifdef FETCH_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            if (jump) begin
                ir_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (imem_read) begin
                        addr_q     <= pc;
                        req_q      <= 1'b1;
                        ir_valid_q <= 1'b0;
                        stale_q    <= jump;
                        state_q    <= WAIT;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (jump) begin
                        stale_q <= 1'b1;
                    end
                    if (imem_ack) begin
                        req_q <= 1'b0;
                        if (squash) begin
                            state_q <= REISSUE;
                        end else begin
                            ir_q       <= imem_rdata;
                            ir_pc_q    <= addr_q;
                            ir_valid_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        req_q <= 1'b0;
                        if (squash) begin
                            state_q <= REISSUE;
                        end else begin
                            ir_q       <= BUS_WIDTH'(NOP);
                            ir_pc_q    <= addr_q;
                            ir_valid_q <= 1'b1;
                            err_q      <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
`endif
                end
                REISSUE: begin
                    addr_q  <= pc;
                    req_q   <= 1'b1;
                    stale_q <= jump;
                    state_q <= WAIT;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign busy      = (state_q != IDLE);

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule
